// File: rtl/sha_mem_responder.sv
// Memory-side responder for the SHA-256 engine: owns the word RAM, serves engine reads,
// loads the message from the host, kicks the engine and streams the hash back out.
module sha_mem_responder #(
    parameter int unsigned DEPTH      = 256,
    parameter int unsigned HASH_WORDS = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        mem_we,
    input  logic [15:0] mem_addr,
    input  logic [31:0] mem_write_data,
    output logic [31:0] mem_read_data,
    input  logic        load_start,
    input  logic [15:0] load_base,
    input  logic [7:0]  load_len,
    input  logic [15:0] out_base,
    input  logic        load_valid,
    input  logic [31:0] load_data,
    output logic        load_ready,
    output logic        eng_start,
    input  logic        eng_done,
    output logic        dump_valid,
    output logic [31:0] dump_data,
    input  logic        dump_ready,
    output logic        busy
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(HASH_WORDS + 1);

    typedef enum logic [2:0] {
        StIdle, StLoad, StKick, StArm, StRun, StDfetch, StDshow
    } state_e;

    state_e        state_q;
    logic [31:0]   ram [DEPTH];
    logic [15:0]   load_base_q;
    logic [15:0]   out_base_q;
    logic [7:0]    load_len_q;
    logic [7:0]    cnt_q;
    logic [CW-1:0] wcnt_q;
    logic [CW-1:0] k_q;

    logic          eng_in_range;
    logic          eng_wr_ok;
    logic          host_wr;
    logic          in_window;
    logic          ram_we;
    logic [AW-1:0] ram_waddr;
    logic [31:0]   ram_wdata;
    logic [15:0]   host_addr;
    logic [15:0]   dump_addr;
    logic [16:0]   win_lo;
    logic [16:0]   win_hi;
    logic          unused_addr_bits;

    assign eng_in_range = (mem_addr >> AW) == '0;
    assign host_wr      = (state_q == StLoad) && load_valid;
    assign eng_wr_ok    = mem_we && eng_in_range && ((state_q == StArm) || (state_q == StRun));
    assign host_addr    = load_base_q + 16'(cnt_q);
    assign dump_addr    = out_base_q + 16'(k_q);
    assign win_lo       = {1'b0, out_base_q};
    assign win_hi       = win_lo + 17'(HASH_WORDS);
    assign in_window    = ({1'b0, mem_addr} >= win_lo) && ({1'b0, mem_addr} < win_hi);

    // Host addresses wrap modulo DEPTH, so their upper bits are deliberately discarded.
    assign unused_addr_bits = ^{host_addr[15:AW], dump_addr[15:AW]};

    // Writes are gated by reset so an aborted job cannot touch the RAM on the reset edge.
    always_comb begin
        ram_we    = reset_n && (host_wr || eng_wr_ok);
        ram_waddr = mem_addr[AW-1:0];
        ram_wdata = mem_write_data;
        if (host_wr) begin
            ram_waddr = host_addr[AW-1:0];
            ram_wdata = load_data;
        end
    end

    always_ff @(posedge clk) begin
        if (ram_we) begin
            ram[ram_waddr] <= ram_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            mem_read_data <= '0;
        end else begin
            mem_read_data <= eng_in_range ? ram[mem_addr[AW-1:0]] : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            load_base_q <= '0;
            out_base_q  <= '0;
            load_len_q  <= '0;
            cnt_q       <= '0;
            wcnt_q      <= '0;
            k_q         <= '0;
            load_ready  <= 1'b0;
            eng_start   <= 1'b0;
            dump_valid  <= 1'b0;
            dump_data   <= '0;
            busy        <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (load_start) begin
                        load_base_q <= load_base;
                        load_len_q  <= load_len;
                        out_base_q  <= out_base;
                        cnt_q       <= '0;
                        wcnt_q      <= '0;
                        k_q         <= '0;
                        busy        <= 1'b1;
                        if (load_len == 8'd0) begin
                            state_q   <= StKick;
                            eng_start <= 1'b1;
                        end else begin
                            state_q    <= StLoad;
                            load_ready <= 1'b1;
                        end
                    end
                end
                StLoad: begin
                    if (load_valid) begin
                        cnt_q <= cnt_q + 8'd1;
                        if (cnt_q == load_len_q - 8'd1) begin
                            state_q    <= StKick;
                            load_ready <= 1'b0;
                            eng_start  <= 1'b1;
                        end
                    end
                end
                StKick: begin
                    eng_start <= 1'b0;
                    state_q   <= StArm;
                end
                StArm: begin
                    if (!eng_done) begin
                        state_q <= StRun;
                    end
                end
                StRun: begin
                    if (mem_we && in_window && (wcnt_q != CW'(HASH_WORDS))) begin
                        wcnt_q <= wcnt_q + 1'b1;
                    end
                    if ((wcnt_q == CW'(HASH_WORDS)) && eng_done) begin
                        state_q <= StDfetch;
                        k_q     <= '0;
                    end
                end
                StDfetch: begin
                    dump_data  <= ram[dump_addr[AW-1:0]];
                    dump_valid <= 1'b1;
                    state_q    <= StDshow;
                end
                StDshow: begin
                    if (dump_ready) begin
                        dump_valid <= 1'b0;
                        k_q        <= k_q + 1'b1;
                        if (k_q == CW'(HASH_WORDS - 1)) begin
                            state_q <= StIdle;
                            busy    <= 1'b0;
                        end else begin
                            state_q <= StDfetch;
                        end
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sha_mem_responder.sv
// Self-checking bench for sha_mem_responder: random host/engine traffic against an
// array-based memory model and the job-level rules of the responder.
module tb_sha_mem_responder;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;
    logic        load_start;
    logic [15:0] load_base;
    logic [7:0]  load_len;
    logic [15:0] out_base;
    logic        load_valid;
    logic [31:0] load_data;
    logic        load_ready;
    logic        eng_start;
    logic        eng_done;
    logic        dump_valid;
    logic [31:0] dump_data;
    logic        dump_ready;
    logic        busy;

    int checks = 0;
    int errors = 0;
    logic [31:0] ref_mem [256];

    always #5 clk = ~clk;

    sha_mem_responder #(.DEPTH(256), .HASH_WORDS(8)) dut (
        .clk(clk), .reset_n(reset_n), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_write_data(mem_write_data), .mem_read_data(mem_read_data),
        .load_start(load_start), .load_base(load_base), .load_len(load_len),
        .out_base(out_base), .load_valid(load_valid), .load_data(load_data),
        .load_ready(load_ready), .eng_start(eng_start), .eng_done(eng_done),
        .dump_valid(dump_valid), .dump_data(dump_data), .dump_ready(dump_ready), .busy(busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic eng_read(input logic [15:0] a, output logic [31:0] d);
        mem_we = 1'b0;
        mem_addr = a;
        tick();
        d = mem_read_data;
    endtask

    task automatic eng_write(input logic [15:0] a, input logic [31:0] d, input bit honoured);
        mem_we = 1'b1;
        mem_addr = a;
        mem_write_data = d;
        tick();
        mem_we = 1'b0;
        if (honoured && a[15:8] == 8'h00) ref_mem[a[7:0]] = d;
    endtask

    task automatic do_load(input logic [15:0] base, input logic [7:0] len,
                           input logic [15:0] ob);
        load_base = base;
        load_len = len;
        out_base = ob;
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        for (int i = 0; i < int'(len); i++) begin
            load_valid = 1'b1;
            load_data = $urandom;
            ref_mem[(int'(base) + i) % 256] = load_data;
            tick();
        end
        load_valid = 1'b0;
    endtask

    task automatic eng_go();
        eng_done = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        tick();
        tick();
        checks++;
        if ({busy, load_ready, eng_start, dump_valid} !== 4'b0000)
            $display("FAIL reset_flags: got %b expected 0000",
                     {busy, load_ready, eng_start, dump_valid});
        checks++;
        if (dump_data !== 32'h0) $display("FAIL reset_dump_data: got %h expected 0", dump_data);
        checks++;
        if (mem_read_data !== 32'h0)
            $display("FAIL reset_read_data: got %h expected 0", mem_read_data);
        errors += int'({busy, load_ready, eng_start, dump_valid} !== 4'b0000)
                + int'(dump_data !== 32'h0) + int'(mem_read_data !== 32'h0);
        reset_n = 1'b1;
        tick();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle_busy: got %b expected 0", busy);
        end
    endtask

    task automatic test_load_read();
        int i = 0;
        int cyc = 0;
        bit gapped = 1'b0;
        logic [31:0] d;
        load_base = 16'h0000;
        load_len = 8'd20;
        out_base = 16'h0080;
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        while (i < 20 && cyc < 200) begin
            checks++;
            if (load_ready !== 1'b1) begin
                errors++;
                $display("FAIL load_ready_high: word %0d got %b expected 1", i, load_ready);
            end
            checks++;
            if (eng_start !== 1'b0) begin
                errors++;
                $display("FAIL early_eng_start: word %0d got %b expected 0", i, eng_start);
            end
            if (!gapped && (i == 3 || i == 7 || $urandom_range(0, 5) == 0)) begin
                load_valid = 1'b0;
                gapped = 1'b1;
            end else begin
                load_valid = 1'b1;
                load_data = 32'h1000 + 32'(i);
                ref_mem[i] = load_data;
                i++;
                gapped = 1'b0;
            end
            tick();
            cyc++;
        end
        load_valid = 1'b0;
        checks++;
        if (i != 20) begin
            errors++;
            $display("FAIL load_timeout: got %0d words expected 20", i);
        end
        checks++;
        if ({eng_start, load_ready, busy} !== 3'b101) begin
            errors++;
            $display("FAIL kick_after_load: got %b expected 101", {eng_start, load_ready, busy});
        end
        tick();
        checks++;
        if (eng_start !== 1'b0) begin
            errors++;
            $display("FAIL eng_start_single: got %b expected 0", eng_start);
        end
        eng_read(16'h0005, d);
        checks++;
        if (d !== 32'h1005) begin
            errors++;
            $display("FAIL read_addr5: got %h expected 00001005", d);
        end
    endtask

    task automatic test_full_job();
        logic [31:0] d;
        logic [31:0] nv;
        eng_done = 1'b0;
        tick();
        for (int i = 0; i < 20; i++) begin
            eng_read(16'(i), d);
            checks++;
            if (d !== ref_mem[i]) begin
                errors++;
                $display("FAIL engine_read: addr %0d got %h expected %h", i, d, ref_mem[i]);
            end
        end
        // Read-during-write on the same index must return the pre-write word.
        nv = $urandom;
        d = ref_mem[5];
        eng_write(16'h0005, nv, 1'b1);
        checks++;
        if (mem_read_data !== d) begin
            errors++;
            $display("FAIL read_during_write: got %h expected %h", mem_read_data, d);
        end
        eng_read(16'h0005, d);
        checks++;
        if (d !== nv) begin
            errors++;
            $display("FAIL write_then_read: got %h expected %h", d, nv);
        end
        for (int i = 0; i < 8; i++) eng_write(16'h0080 + 16'(i), $urandom, 1'b1);
        eng_done = 1'b1;
    endtask

    task automatic test_dump_backpressure(input logic [15:0] base, input int stall_word);
        int got = 0;
        int stall = 0;
        int cyc = 0;
        logic [31:0] exp;
        dump_ready = 1'b0;
        while (got < 8 && cyc < 300) begin
            tick();
            cyc++;
            dump_ready = 1'b0;
            if (dump_valid) begin
                exp = ref_mem[(int'(base) + got) % 256];
                checks++;
                if (dump_data !== exp) begin
                    errors++;
                    $display("FAIL dump_word: index %0d got %h expected %h", got, dump_data, exp);
                end
                if (got == stall_word && stall < 5) stall++;
                else if (got != stall_word && $urandom_range(0, 3) == 0) dump_ready = 1'b0;
                else begin
                    dump_ready = 1'b1;
                    got++;
                end
            end
        end
        checks++;
        if (got != 8 || stall != 5) begin
            errors++;
            $display("FAIL dump_count: got %0d words, %0d stalls expected 8 words, 5 stalls",
                     got, stall);
        end
        tick();
        dump_ready = 1'b0;
        checks++;
        if ({busy, dump_valid} !== 2'b00) begin
            errors++;
            $display("FAIL dump_end_idle: got %b expected 00", {busy, dump_valid});
        end
    endtask

    task automatic test_reset_mid_load();
        logic [31:0] d0;
        logic [31:0] d;
        load_base = 16'h0008;
        load_len = 8'd4;
        out_base = 16'h0080;
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        d0 = $urandom;
        load_valid = 1'b1;
        load_data = d0;
        ref_mem[8] = d0;
        tick();
        load_data = ~d0;
        reset_n = 1'b0;
        tick();
        tick();
        checks++;
        if ({busy, load_ready, eng_start, dump_valid} !== 4'b0000 || mem_read_data !== 32'h0) begin
            errors++;
            $display("FAIL midload_reset_outputs: got %b/%h expected 0000/0",
                     {busy, load_ready, eng_start, dump_valid}, mem_read_data);
        end
        reset_n = 1'b1;
        tick();
        tick();
        load_valid = 1'b0;
        eng_read(16'h0009, d);
        checks++;
        if (d !== ref_mem[9]) begin
            errors++;
            $display("FAIL midload_no_write: got %h expected %h", d, ref_mem[9]);
        end
        eng_read(16'h0008, d);
        checks++;
        if (d !== d0) begin
            errors++;
            $display("FAIL midload_first_word: got %h expected %h", d, d0);
        end
    endtask

    task automatic test_boundaries();
        logic [31:0] d;
        logic [15:0] idx [4];
        idx = '{16'h00FE, 16'h00FF, 16'h0000, 16'h0001};
        eng_write(16'h0080, $urandom, 1'b0);
        eng_read(16'h0080, d);
        checks++;
        if (d !== ref_mem[8'h80]) begin
            errors++;
            $display("FAIL idle_write_dropped: got %h expected %h", d, ref_mem[8'h80]);
        end
        do_load(16'h00FE, 8'd4, 16'h0008);
        eng_go();
        foreach (idx[j]) begin
            eng_read(idx[j], d);
            checks++;
            if (d !== ref_mem[idx[j][7:0]]) begin
                errors++;
                $display("FAIL wrap_load: addr %h got %h expected %h", idx[j], d,
                         ref_mem[idx[j][7:0]]);
            end
        end
        eng_write(16'h0100, $urandom, 1'b1);
        eng_read(16'h0100, d);
        checks++;
        if (d !== 32'h0) begin
            errors++;
            $display("FAIL out_of_range_read: got %h expected 0", d);
        end
        eng_read(16'h0000, d);
        checks++;
        if (d !== ref_mem[0]) begin
            errors++;
            $display("FAIL out_of_range_alias: got %h expected %h", d, ref_mem[0]);
        end
        // Duplicate hit on 0x08 plus 0x09..0x0D: seven counted writes, one short of done.
        eng_write(16'h0008, $urandom, 1'b1);
        for (int i = 8; i < 14; i++) eng_write(16'(i), $urandom, 1'b1);
        eng_done = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if ({busy, dump_valid} !== 2'b10) begin
                errors++;
                $display("FAIL wait_eighth_write: got %b expected 10", {busy, dump_valid});
            end
        end
        eng_write(16'h000E, $urandom, 1'b1);
        test_dump_backpressure(16'h0008, int'($urandom_range(0, 7)));
    endtask

    task automatic test_zero_len();
        do_load(16'h0000, 8'd0, 16'h0030);
        checks++;
        if ({eng_start, load_ready, busy} !== 3'b101) begin
            errors++;
            $display("FAIL zero_len_kick: got %b expected 101", {eng_start, load_ready, busy});
        end
        eng_go();
        load_base = 16'h0000;
        load_len = 8'd5;
        out_base = 16'h0040;
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        checks++;
        if ({eng_start, load_ready, busy} !== 3'b001) begin
            errors++;
            $display("FAIL start_in_run: got %b expected 001", {eng_start, load_ready, busy});
        end
        for (int i = 0; i < 8; i++) eng_write(16'h0030 + 16'(i), $urandom, 1'b1);
        eng_done = 1'b1;
        test_dump_backpressure(16'h0030, int'($urandom_range(0, 7)));
    endtask

    initial begin
        reset_n = 1'b0;
        mem_we = 1'b0;
        mem_addr = '0;
        mem_write_data = '0;
        load_start = 1'b0;
        load_base = '0;
        load_len = '0;
        out_base = '0;
        load_valid = 1'b0;
        load_data = '0;
        eng_done = 1'b1;
        dump_ready = 1'b0;
        test_reset();
        test_load_read();
        test_full_job();
        test_dump_backpressure(16'h0080, 2);
        test_reset_mid_load();
        test_boundaries();
        test_zero_len();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1);
    end

endmodule
